// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-producer FIFOs, round-robin grant onto one registered bus.
// Optional direct FIFO bypass when all FIFOs are empty: define CDB_BYPASS_EN.
`ifndef ROB_IDX_WIDTH
`define ROB_IDX_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module cdb_arbiter #(
   parameter int BUF_DEPTH = 2,
   parameter int NUM_SRC   = 3
) (
   input  logic                      clk,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      roll_back,
   input  logic                      alu_en,
   input  logic [`ROB_IDX_WIDTH-1:0] alu_rob_idx,
   input  logic [`DATA_WIDTH-1:0]    alu_val,
   input  logic                      ld_en,
   input  logic [`ROB_IDX_WIDTH-1:0] ld_rob_idx,
   input  logic [`DATA_WIDTH-1:0]    ld_val,
   input  logic                      st_en,
   input  logic [`ROB_IDX_WIDTH-1:0] st_rob_idx,
   output logic                      alu_full,
   output logic                      ld_full,
   output logic                      st_full,
   output logic                      cdb_en,
   output logic [`ROB_IDX_WIDTH-1:0] cdb_rob_idx,
   output logic [`DATA_WIDTH-1:0]    cdb_val
);

   localparam int IW = `ROB_IDX_WIDTH;
   localparam int DW = `DATA_WIDTH;
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

   logic [IW-1:0] idx_mem_q [NUM_SRC][BUF_DEPTH];
   logic [DW-1:0] val_mem_q [NUM_SRC][BUF_DEPTH];
   logic [PW-1:0] head_q    [NUM_SRC];
   logic [PW-1:0] tail_q    [NUM_SRC];
   logic [CW-1:0] cnt_q     [NUM_SRC];
   logic [CW-1:0] cnt_d     [NUM_SRC];
   logic [1:0]    rr_q, rr_d;
   logic          cdb_en_q, cdb_en_d;
   logic [IW-1:0] cdb_idx_q, cdb_idx_d;
   logic [DW-1:0] cdb_val_q, cdb_val_d;

   logic          src_en   [NUM_SRC];
   logic [IW-1:0] src_idx  [NUM_SRC];
   logic [DW-1:0] src_val  [NUM_SRC];
   logic          full     [NUM_SRC];
   logic          empty    [NUM_SRC];
   logic          push     [NUM_SRC];
   logic          pop      [NUM_SRC];
   logic          gnt_vld, byp_vld;
   logic [1:0]    gnt_src, byp_src;
   int unsigned   sel;

   function automatic logic [1:0] rr_next(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   always_comb begin
      src_en[0]  = alu_en;
      src_en[1]  = ld_en;
      src_en[2]  = st_en;
      src_idx[0] = alu_rob_idx;
      src_idx[1] = ld_rob_idx;
      src_idx[2] = st_rob_idx;
      src_val[0] = alu_val;
      src_val[1] = ld_val;
      src_val[2] = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         full[s]  = (cnt_q[s] == FULL_CNT);
         empty[s] = (cnt_q[s] == '0);
         push[s]  = src_en[s] && !full[s];
         pop[s]   = 1'b0;
      end

      // Search begins at the round-robin pointer and wraps once around all sources.
      gnt_vld = 1'b0;
      gnt_src = '0;
      sel     = 0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         sel = (32'(rr_q) + k) % 32'(NUM_SRC);
         if (!gnt_vld && !empty[sel]) begin
            gnt_vld = 1'b1;
            gnt_src = 2'(sel);
         end
      end
      if (gnt_vld) pop[gnt_src] = 1'b1;

      byp_vld = 1'b0;
      byp_src = '0;
`ifdef CDB_BYPASS_EN
      if (empty[0] && empty[1] && empty[2] && ($countones({alu_en, ld_en, st_en}) == 1)) begin
         byp_vld       = 1'b1;
         byp_src       = alu_en ? 2'd0 : (ld_en ? 2'd1 : 2'd2);
         push[byp_src] = 1'b0;
      end
`endif

      for (int unsigned s = 0; s < NUM_SRC; s++)
         cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);

      cdb_en_d  = 1'b0;
      cdb_idx_d = cdb_idx_q;
      cdb_val_d = cdb_val_q;
      rr_d      = rr_q;
      if (gnt_vld) begin
         cdb_en_d  = 1'b1;
         cdb_idx_d = idx_mem_q[gnt_src][head_q[gnt_src]];
         cdb_val_d = val_mem_q[gnt_src][head_q[gnt_src]];
         rr_d      = rr_next(gnt_src);
      end else if (byp_vld) begin
         cdb_en_d  = 1'b1;
         cdb_idx_d = src_idx[byp_src];
         cdb_val_d = src_val[byp_src];
         rr_d      = rr_next(byp_src);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int unsigned s = 0; s < NUM_SRC; s++) begin
            cnt_q[s]  <= '0;
            head_q[s] <= '0;
            tail_q[s] <= '0;
         end
         rr_q      <= '0;
         cdb_en_q  <= 1'b0;
         cdb_idx_q <= '0;
         cdb_val_q <= '0;
      end else if (rdy_in) begin
         if (roll_back) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
               cnt_q[s]  <= '0;
               head_q[s] <= '0;
               tail_q[s] <= '0;
            end
            rr_q     <= '0;
            cdb_en_q <= 1'b0;
         end else begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
               cnt_q[s] <= cnt_d[s];
               if (push[s]) begin
                  idx_mem_q[s][tail_q[s]] <= src_idx[s];
                  val_mem_q[s][tail_q[s]] <= src_val[s];
                  tail_q[s]               <= tail_q[s] + 1'b1;
               end
               if (pop[s]) head_q[s] <= head_q[s] + 1'b1;
            end
            rr_q      <= rr_d;
            cdb_en_q  <= cdb_en_d;
            cdb_idx_q <= cdb_idx_d;
            cdb_val_q <= cdb_val_d;
         end
      end
   end

   assign alu_full    = full[0];
   assign ld_full     = full[1];
   assign st_full     = full[2];
   assign cdb_en      = cdb_en_q;
   assign cdb_rob_idx = cdb_idx_q;
   assign cdb_val     = cdb_val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: table of single-cycle producer patterns plus
// hand-written streaming, roll-back and freeze sequences, all scored through one queue.
`ifndef ROB_IDX_WIDTH
`define ROB_IDX_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_cdb_arbiter;
   localparam int IW = `ROB_IDX_WIDTH;
   localparam int DW = `DATA_WIDTH;
`ifdef CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_in, rdy_in, roll_back;
   logic          alu_en, ld_en, st_en;
   logic [IW-1:0] alu_rob_idx, ld_rob_idx, st_rob_idx;
   logic [DW-1:0] alu_val, ld_val;
   logic          alu_full, ld_full, st_full, cdb_en;
   logic [IW-1:0] cdb_rob_idx;
   logic [DW-1:0] cdb_val;

   cdb_arbiter #(.BUF_DEPTH(2), .NUM_SRC(3)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
      .alu_en(alu_en), .alu_rob_idx(alu_rob_idx), .alu_val(alu_val),
      .ld_en(ld_en), .ld_rob_idx(ld_rob_idx), .ld_val(ld_val),
      .st_en(st_en), .st_rob_idx(st_rob_idx),
      .alu_full(alu_full), .ld_full(ld_full), .st_full(st_full),
      .cdb_en(cdb_en), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [DW-1:0] val;
   } bc_t;

   typedef struct {
      logic          a_en;
      logic [IW-1:0] a_idx;
      logic [DW-1:0] a_val;
      logic          l_en;
      logic [IW-1:0] l_idx;
      logic [DW-1:0] l_val;
      logic          s_en;
      logic [IW-1:0] s_idx;
      int            exp_n;
   } vec_t;

   bc_t  sb[$];
   int   checks = 0, failures = 0;
   int   cyc, nb, first_cyc, last_cyc;
   bit   mon_en = 1'b1;
   int   model_rr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      bc_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en && cdb_en === 1'b1) begin
         nb++;
         last_cyc = cyc;
         if (first_cyc < 0) first_cyc = cyc;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bcast actual=idx %0h val %0h required=no broadcast", cdb_rob_idx, cdb_val);
         end else begin
            e = sb.pop_front();
            chk("bcast_idx", 64'(cdb_rob_idx), 64'(e.idx));
            chk("bcast_val", 64'(cdb_val), 64'(e.val));
         end
      end
   endtask

   task automatic clear_in();
      alu_en = 0; ld_en = 0; st_en = 0; roll_back = 0;
      alu_rob_idx = '0; ld_rob_idx = '0; st_rob_idx = '0; alu_val = '0; ld_val = '0;
   endtask

   task automatic do_reset();
      rst_in = 1;
      step();
      step();
      rst_in = 0;
      model_rr = 0;
   endtask

   task automatic drain(input string nm);
      for (int c = 0; c < 20 && sb.size() > 0; c++) step();
      repeat (3) step();
      chk(nm, 64'(sb.size()), 64'd0);
   endtask

   vec_t vt[8];
   bit   en3[3];
   bc_t  ent3[3];
   int   last_s, exp_first, k, guard;
   bit   was_full, saw_full;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1, 4'h1, 32'hA,    1, 4'h2, 32'hB,    1, 4'h4, 3};
      vt[1] = '{1, 4'h3, 32'h1234, 0, 4'h0, 32'h0,    0, 4'h0, 1};
      vt[2] = '{0, 4'h0, 32'h0,    1, 4'h6, 32'hDEAD, 0, 4'h0, 1};
      vt[3] = '{0, 4'h0, 32'h0,    0, 4'h0, 32'h0,    1, 4'h7, 1};
      vt[4] = '{1, 4'h9, 32'h99,   0, 4'h0, 32'h0,    1, 4'hA, 2};
      vt[5] = '{0, 4'h0, 32'h0,    1, 4'hB, 32'h77,   1, 4'hC, 2};
      vt[6] = '{1, 4'hD, 32'h13,   0, 4'h0, 32'h0,    0, 4'h0, 1};
      vt[7] = '{1, 4'hE, 32'h14,   1, 4'hF, 32'h15,   1, 4'h0, 3};

      clear_in();
      rdy_in = 1;
      cyc = 0; nb = 0; first_cyc = -1; last_cyc = -1;
      do_reset();
      repeat (5) step();
      chk("rst_cdb_en",  64'(cdb_en), 64'd0);
      chk("rst_cdb_idx", 64'(cdb_rob_idx), 64'd0);
      chk("rst_cdb_val", 64'(cdb_val), 64'd0);
      chk("rst_full", 64'({alu_full, ld_full, st_full}), 64'd0);

      // Table: each record is one cycle of producer input; order comes from the RR model.
      for (int v = 0; v < 8; v++) begin
         en3[0] = vt[v].a_en; ent3[0] = '{vt[v].a_idx, vt[v].a_val};
         en3[1] = vt[v].l_en; ent3[1] = '{vt[v].l_idx, vt[v].l_val};
         en3[2] = vt[v].s_en; ent3[2] = '{vt[v].s_idx, '0};
         last_s = model_rr;
         for (int j = 0; j < 3; j++) begin
            if (en3[(model_rr + j) % 3]) begin
               sb.push_back(ent3[(model_rr + j) % 3]);
               last_s = (model_rr + j) % 3;
            end
         end
         model_rr = (last_s + 1) % 3;
         exp_first = (BYP && vt[v].exp_n == 1) ? 1 : 2;

         alu_en = vt[v].a_en; alu_rob_idx = vt[v].a_idx; alu_val = vt[v].a_val;
         ld_en  = vt[v].l_en; ld_rob_idx  = vt[v].l_idx; ld_val  = vt[v].l_val;
         st_en  = vt[v].s_en; st_rob_idx  = vt[v].s_idx;
         cyc = 0; nb = 0; first_cyc = -1; last_cyc = -1;
         step();
         clear_in();
         for (int c = 0; c < 8 && sb.size() > 0; c++) step();
         repeat (2) step();
         chk("vec_drain", 64'(sb.size()), 64'd0);
         chk("vec_count", 64'(nb), 64'(vt[v].exp_n));
         chk("vec_latency", 64'(first_cyc), 64'(exp_first));
         chk("vec_back_to_back", 64'(last_cyc), 64'(exp_first + vt[v].exp_n - 1));
      end

      // ALU streams 6 results honouring alu_full; one load alongside the first.
      do_reset();
      sb.push_back('{4'h8, 32'hA000});
      sb.push_back('{4'h5, 32'h55});
      for (int i = 1; i < 6; i++) sb.push_back('{IW'(8 + i), DW'(32'hA000 + i)});
      k = 0; guard = 0; saw_full = 0;
      ld_en = 1; ld_rob_idx = 4'h5; ld_val = 32'h55;
      while (k < 6 && guard < 40) begin
         alu_en = 1; alu_rob_idx = IW'(8 + k); alu_val = DW'(32'hA000 + k);
         was_full = alu_full;
         step();
         guard++;
         ld_en = 0;
         if (alu_full) saw_full = 1;
         if (!was_full) k++;
      end
      clear_in();
      chk("stream_all_accepted", 64'(k), 64'd6);
      chk("stream_alu_full_seen", 64'(saw_full), 64'd1);
      drain("stream_drain");

      // Fill the load FIFO, then roll back with a simultaneous store push.
      do_reset();
      sb.push_back('{4'h1, 32'h21});
      alu_en = 1; alu_rob_idx = 4'h1; alu_val = 32'h21;
      ld_en  = 1; ld_rob_idx  = 4'h2; ld_val  = 32'h22;
      step();
      alu_rob_idx = 4'h3; alu_val = 32'h23;
      ld_rob_idx  = 4'h4; ld_val  = 32'h24;
      step();
      chk("pre_flush_ld_full", 64'(ld_full), 64'd1);
      clear_in();
      roll_back = 1; st_en = 1; st_rob_idx = 4'h5;
      step();
      clear_in();
      chk("flush_cdb_en", 64'(cdb_en), 64'd0);
      chk("flush_full", 64'({alu_full, ld_full, st_full}), 64'd0);
      repeat (6) step();
      chk("flush_nothing_left", 64'(sb.size()), 64'd0);

      // Freeze with a broadcast on the bus and one entry still queued.
      do_reset();
      sb.push_back('{4'h6, 32'h66});
      sb.push_back('{4'h7, 32'h77});
      alu_en = 1; alu_rob_idx = 4'h6; alu_val = 32'h66;
      ld_en  = 1; ld_rob_idx  = 4'h7; ld_val  = 32'h77;
      step();
      clear_in();
      step();
      rdy_in = 0; mon_en = 0;
      st_en = 1; st_rob_idx = 4'h8; ld_en = 1; ld_rob_idx = 4'h9; ld_val = 32'h99;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("freeze_cdb", 64'({cdb_en, cdb_rob_idx, cdb_val}), 64'({1'b1, 4'h6, 32'h66}));
      end
      clear_in();
      rdy_in = 1; mon_en = 1;
      step();
      chk("thaw_first_is_ld", 64'(sb.size()), 64'd0);
      drain("freeze_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
